// File: rtl/rob_queue.sv
// rtl/rob_queue.sv - reorder buffer: in-order dispatch, out-of-order writeback, in-order multi-lane commit
module rob_queue #(
  parameter int ROB_DEPTH       = 16,
  parameter int COMMIT_W        = 2,
  parameter int WB_PORTS        = 2,
  parameter int INSTR_MEM_IDX_W = 16,
  parameter int ARCH_REG_IDX_W  = 5,
  parameter int PHYS_REG_IDX_W  = 6,
  parameter int INT_DATA_W      = 32,
  localparam int RIW            = $clog2(ROB_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  disp_valid,
  output logic                                  disp_ready,
  input  logic [INSTR_MEM_IDX_W-1:0]            disp_pc,
  input  logic [ARCH_REG_IDX_W-1:0]             disp_logical_rd,
  input  logic [PHYS_REG_IDX_W-1:0]             disp_phys_rd,
  input  logic                                  disp_is_store,
  input  logic                                  disp_is_load,
  output logic [RIW-1:0]                        disp_idx,
  input  logic [WB_PORTS-1:0]                   wb_valid,
  input  logic [WB_PORTS*RIW-1:0]               wb_idx,
  input  logic [WB_PORTS*INT_DATA_W-1:0]        wb_result,
  output logic [COMMIT_W-1:0]                   commit_valid,
  input  logic                                  commit_ready,
  output logic [COMMIT_W*INSTR_MEM_IDX_W-1:0]   commit_pc,
  output logic [COMMIT_W*ARCH_REG_IDX_W-1:0]    commit_logical_rd,
  output logic [COMMIT_W*PHYS_REG_IDX_W-1:0]    commit_phys_rd,
  output logic [COMMIT_W*INT_DATA_W-1:0]        commit_result,
  output logic [COMMIT_W-1:0]                   commit_is_store,
  output logic [COMMIT_W-1:0]                   commit_is_load,
  output logic [RIW:0]                          count,
  output logic                                  empty,
  output logic                                  full
);

  logic                       valid_q  [ROB_DEPTH];
  logic                       valid_d  [ROB_DEPTH];
  logic                       done_q   [ROB_DEPTH];
  logic                       done_d   [ROB_DEPTH];
  logic [INT_DATA_W-1:0]      result_q [ROB_DEPTH];
  logic [INT_DATA_W-1:0]      result_d [ROB_DEPTH];
  logic [INSTR_MEM_IDX_W-1:0] pc_q     [ROB_DEPTH];
  logic [ARCH_REG_IDX_W-1:0]  lrd_q    [ROB_DEPTH];
  logic [PHYS_REG_IDX_W-1:0]  prd_q    [ROB_DEPTH];
  logic                       st_q     [ROB_DEPTH];
  logic                       ld_q     [ROB_DEPTH];

  logic [RIW-1:0] head_q, head_d, tail_q, tail_d;
  logic [RIW:0]   count_q, count_d;
  logic [RIW:0]   n_elig, n_retire;
  logic [RIW-1:0] lane_idx, ret_idx, wb_tgt;
  logic           elig, store_seen, disp_fire;

  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == (RIW+1)'(ROB_DEPTH));
  assign disp_ready = !full && !flush;
  assign disp_idx   = tail_q;
  assign disp_fire  = disp_valid && disp_ready;
  assign n_retire   = commit_ready ? n_elig : '0;

  // Eligibility chains lane to lane so commit_valid is always a prefix; one store per cycle.
  always_comb begin
    commit_valid      = '0;
    commit_pc         = '0;
    commit_logical_rd = '0;
    commit_phys_rd    = '0;
    commit_result     = '0;
    commit_is_store   = '0;
    commit_is_load    = '0;
    n_elig            = '0;
    elig              = 1'b1;
    store_seen        = 1'b0;
    lane_idx          = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_idx = head_q + RIW'(k);
      commit_pc[k*INSTR_MEM_IDX_W +: INSTR_MEM_IDX_W]      = pc_q[lane_idx];
      commit_logical_rd[k*ARCH_REG_IDX_W +: ARCH_REG_IDX_W] = lrd_q[lane_idx];
      commit_phys_rd[k*PHYS_REG_IDX_W +: PHYS_REG_IDX_W]    = prd_q[lane_idx];
      commit_result[k*INT_DATA_W +: INT_DATA_W]             = result_q[lane_idx];
      commit_is_store[k] = st_q[lane_idx];
      commit_is_load[k]  = ld_q[lane_idx];
      elig = elig && ((RIW+1)'(k) < count_q) && valid_q[lane_idx] && done_q[lane_idx]
             && !(st_q[lane_idx] && store_seen) && !flush;
      commit_valid[k] = elig;
      if (elig) begin
        n_elig = n_elig + 1'b1;
        if (st_q[lane_idx]) store_seen = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    result_d = result_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ret_idx  = '0;
    wb_tgt   = '0;
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Ascending port order lets the highest port win; the dispatch target is invalid, so it is skipped.
      for (int p = 0; p < WB_PORTS; p++) begin
        wb_tgt = wb_idx[p*RIW +: RIW];
        if (wb_valid[p] && valid_q[wb_tgt]) begin
          done_d[wb_tgt]   = 1'b1;
          result_d[wb_tgt] = wb_result[p*INT_DATA_W +: INT_DATA_W];
        end
      end
      if (commit_ready) begin
        for (int k = 0; k < COMMIT_W; k++) begin
          ret_idx = head_q + RIW'(k);
          if (commit_valid[k]) begin
            valid_d[ret_idx] = 1'b0;
            done_d[ret_idx]  = 1'b0;
          end
        end
      end
      if (disp_fire) begin
        valid_d[tail_q]  = 1'b1;
        done_d[tail_q]   = 1'b0;
        result_d[tail_q] = '0;
        tail_d           = tail_q + 1'b1;
      end
      head_d  = head_q + n_retire[RIW-1:0];
      count_d = count_q + {{RIW{1'b0}}, disp_fire} - n_retire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        done_q[i]   <= 1'b0;
        result_q[i] <= '0;
        pc_q[i]     <= '0;
        lrd_q[i]    <= '0;
        prd_q[i]    <= '0;
        st_q[i]     <= 1'b0;
        ld_q[i]     <= 1'b0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      result_q <= result_d;
      if (disp_fire) begin
        pc_q[tail_q]  <= disp_pc;
        lrd_q[tail_q] <= disp_logical_rd;
        prd_q[tail_q] <= disp_phys_rd;
        st_q[tail_q]  <= disp_is_store;
        ld_q[tail_q]  <= disp_is_load;
      end
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// tb/tb_rob_queue.sv - vector-table bench for rob_queue
module tb_rob_queue;
  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready, disp_is_store, disp_is_load, commit_ready;
  logic [15:0] disp_pc;
  logic [4:0]  disp_logical_rd;
  logic [5:0]  disp_phys_rd;
  logic [3:0]  disp_idx;
  logic [1:0]  wb_valid, commit_valid, commit_is_store, commit_is_load;
  logic [7:0]  wb_idx;
  logic [63:0] wb_result, commit_result;
  logic [31:0] commit_pc;
  logic [9:0]  commit_logical_rd;
  logic [11:0] commit_phys_rd;
  logic [4:0]  count;
  logic        empty, full;

  always #5 clk = ~clk;

  rob_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pc(disp_pc),
    .disp_logical_rd(disp_logical_rd), .disp_phys_rd(disp_phys_rd),
    .disp_is_store(disp_is_store), .disp_is_load(disp_is_load), .disp_idx(disp_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_result(wb_result),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_logical_rd(commit_logical_rd), .commit_phys_rd(commit_phys_rd),
    .commit_result(commit_result), .commit_is_store(commit_is_store),
    .commit_is_load(commit_is_load), .count(count), .empty(empty), .full(full)
  );

  typedef struct packed {
    logic rst, flush, dv, dst;
    logic [15:0] dpc;
    logic [1:0]  wbv;
    logic [3:0]  wi0, wi1;
    logic [31:0] wr0, wr1;
    logic        cr, ck;
    logic [1:0]  ecv;
    logic [4:0]  ecnt;
    logic        edr;
    logic [3:0]  edidx;
    logic [15:0] epc0, epc1;
    logic [31:0] eres0, eres1;
  } vec_t;

  vec_t tbl[$];
  int applied = 0;
  int miscompares = 0;

  function automatic vec_t idle(input logic cr);
    vec_t v = '0;
    v.cr = cr;
    return v;
  endfunction

  function automatic vec_t disp(input logic [15:0] pc, input logic st);
    vec_t v = '0;
    v.dv = 1'b1; v.dpc = pc; v.dst = st;
    return v;
  endfunction

  function automatic vec_t wb(input logic [1:0] m, input logic [3:0] i0, input logic [31:0] r0,
                              input logic [3:0] i1, input logic [31:0] r1, input logic cr);
    vec_t v = '0;
    v.wbv = m; v.wi0 = i0; v.wr0 = r0; v.wi1 = i1; v.wr1 = r1; v.cr = cr;
    return v;
  endfunction

  function automatic vec_t E(input vec_t vi, input logic [1:0] cv, input logic [4:0] cnt,
                             input logic dr, input logic [3:0] didx,
                             input logic [15:0] pc0, input logic [31:0] r0,
                             input logic [15:0] pc1, input logic [31:0] r1);
    vec_t v = vi;
    v.ck = 1'b1; v.ecv = cv; v.ecnt = cnt; v.edr = dr; v.edidx = didx;
    v.epc0 = pc0; v.eres0 = r0; v.epc1 = pc1; v.eres1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    @(negedge clk);
    rst = v.rst; flush = v.flush; disp_valid = v.dv; disp_is_store = v.dst; disp_is_load = 1'b0;
    disp_pc = v.dpc; disp_logical_rd = v.dpc[4:0]; disp_phys_rd = v.dpc[5:0];
    wb_valid = v.wbv; wb_idx = {v.wi1, v.wi0}; wb_result = {v.wr1, v.wr0}; commit_ready = v.cr;
    #1;
    if (v.ck) begin
      applied++;
      chk("commit_valid", n, 32'(commit_valid), 32'(v.ecv));
      chk("count", n, 32'(count), 32'(v.ecnt));
      chk("disp_ready", n, 32'(disp_ready), 32'(v.edr));
      chk("disp_idx", n, 32'(disp_idx), 32'(v.edidx));
      chk("empty", n, 32'(empty), 32'(v.ecnt == 5'd0));
      chk("full", n, 32'(full), 32'(v.ecnt == 5'd16));
      if (v.ecv[0]) begin
        chk("lane0_pc", n, 32'(commit_pc[15:0]), 32'(v.epc0));
        chk("lane0_lrd", n, 32'(commit_logical_rd[4:0]), 32'(v.epc0[4:0]));
        chk("lane0_result", n, commit_result[31:0], v.eres0);
      end
      if (v.ecv[1]) begin
        chk("lane1_pc", n, 32'(commit_pc[31:16]), 32'(v.epc1));
        chk("lane1_result", n, commit_result[63:32], v.eres1);
      end
    end
  endtask

  initial begin
    vec_t v;
    // Reset, then out-of-order completion of A/B/C
    v = '0; v.rst = 1'b1;
    tbl.push_back(v);
    tbl.push_back(v);
    tbl.push_back(E(disp(16'h100, 0), 2'b00, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(E(disp(16'h101, 0), 2'b00, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(E(disp(16'h102, 0), 2'b00, 2, 1, 2, 0, 0, 0, 0));
    tbl.push_back(E(wb(2'b11, 2, 32'h33, 0, 32'h11, 0), 2'b00, 3, 1, 3, 0, 0, 0, 0));
    tbl.push_back(E(idle(1), 2'b01, 3, 1, 3, 16'h100, 32'h11, 0, 0));
    tbl.push_back(E(wb(2'b01, 1, 32'h22, 0, 0, 0), 2'b00, 2, 1, 3, 0, 0, 0, 0));
    tbl.push_back(E(idle(1), 2'b11, 2, 1, 3, 16'h101, 32'h22, 16'h102, 32'h33));
    // Store limit and same-index port conflict
    tbl.push_back(E(disp(16'h110, 1), 2'b00, 0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(E(disp(16'h111, 1), 2'b00, 1, 1, 4, 0, 0, 0, 0));
    tbl.push_back(E(disp(16'h112, 0), 2'b00, 2, 1, 5, 0, 0, 0, 0));
    tbl.push_back(E(wb(2'b11, 3, 32'hAA, 3, 32'hBB, 0), 2'b00, 3, 1, 6, 0, 0, 0, 0));
    tbl.push_back(E(wb(2'b01, 4, 32'h44, 0, 0, 0), 2'b01, 3, 1, 6, 16'h110, 32'hBB, 0, 0));
    tbl.push_back(E(wb(2'b10, 0, 0, 5, 32'h55, 0), 2'b01, 3, 1, 6, 16'h110, 32'hBB, 0, 0));
    tbl.push_back(E(idle(1), 2'b01, 3, 1, 6, 16'h110, 32'hBB, 0, 0));
    tbl.push_back(E(idle(1), 2'b11, 2, 1, 6, 16'h111, 32'h44, 16'h112, 32'h55));
    // Walk head to 14, then commit across the wrap while dispatching
    for (int i = 0; i < 8; i++) tbl.push_back(disp(16'(16'h200 + i), 0));
    for (int j = 0; j < 4; j++)
      tbl.push_back(wb(2'b11, 4'(6 + 2*j), 32'(32'h1006 + 2*j), 4'(7 + 2*j), 32'(32'h1007 + 2*j), 0));
    for (int j = 0; j < 4; j++) tbl.push_back(idle(1));
    for (int i = 0; i < 4; i++) tbl.push_back(disp(16'(16'h210 + i), 0));
    tbl.push_back(wb(2'b11, 14, 32'h200E, 15, 32'h200F, 0));
    tbl.push_back(wb(2'b11, 0, 32'h2000, 1, 32'h2001, 0));
    v = disp(16'h300, 0); v.cr = 1'b1;
    tbl.push_back(E(v, 2'b11, 4, 1, 2, 16'h210, 32'h200E, 16'h211, 32'h200F));
    tbl.push_back(E(idle(0), 2'b11, 3, 1, 3, 16'h212, 32'h2000, 16'h213, 32'h2001));
    tbl.push_back(E(idle(1), 2'b11, 3, 1, 3, 16'h212, 32'h2000, 16'h213, 32'h2001));
    tbl.push_back(E(wb(2'b01, 2, 32'h77, 0, 0, 0), 2'b00, 1, 1, 3, 0, 0, 0, 0));
    tbl.push_back(E(idle(1), 2'b01, 1, 1, 3, 16'h300, 32'h77, 0, 0));
    // Flush with dispatch, writeback and commit all active
    for (int i = 0; i < 4; i++) tbl.push_back(disp(16'(16'h400 + i), 0));
    v = disp(16'h404, 0); v.wbv = 2'b11; v.wi0 = 3; v.wr0 = 32'h4; v.wi1 = 4; v.wr1 = 32'h5;
    tbl.push_back(E(v, 2'b00, 4, 1, 7, 0, 0, 0, 0));
    tbl.push_back(E(idle(0), 2'b11, 5, 1, 8, 16'h400, 32'h4, 16'h401, 32'h5));
    v = disp(16'h405, 0); v.flush = 1'b1; v.wbv = 2'b01; v.wi0 = 5; v.wr0 = 32'h9; v.cr = 1'b1;
    tbl.push_back(E(v, 2'b00, 5, 0, 8, 0, 0, 0, 0));
    tbl.push_back(E(idle(0), 2'b00, 0, 1, 0, 0, 0, 0, 0));
    // Writebacks to an invalid entry and to the entry being dispatched are dropped
    tbl.push_back(E(wb(2'b01, 0, 32'hDEAD, 0, 0, 0), 2'b00, 0, 1, 0, 0, 0, 0, 0));
    v = disp(16'h500, 0); v.wbv = 2'b01; v.wi0 = 0; v.wr0 = 32'hBEEF;
    tbl.push_back(E(v, 2'b00, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(E(idle(1), 2'b00, 1, 1, 1, 0, 0, 0, 0));
    v = '0; v.flush = 1'b1;
    tbl.push_back(v);
    // Fill to 16, refuse a 17th, refuse dispatch even while committing from full
    for (int i = 0; i < 16; i++) tbl.push_back(E(disp(16'(i), 0), 2'b00, 5'(i), 1, 4'(i), 0, 0, 0, 0));
    tbl.push_back(E(disp(16'h99, 0), 2'b00, 16, 0, 0, 0, 0, 0, 0));
    tbl.push_back(E(wb(2'b11, 0, 32'hA0, 1, 32'hA1, 0), 2'b00, 16, 0, 0, 0, 0, 0, 0));
    v = disp(16'h98, 0); v.cr = 1'b1;
    tbl.push_back(E(v, 2'b11, 16, 0, 0, 16'h0, 32'hA0, 16'h1, 32'hA1));
    tbl.push_back(E(idle(0), 2'b00, 14, 1, 0, 0, 0, 0, 0));
    // Reset held two cycles mid-traffic
    v = disp(16'h97, 0); v.rst = 1'b1; v.cr = 1'b1; v.wbv = 2'b01; v.wi0 = 2; v.wr0 = 32'h1;
    tbl.push_back(v);
    v = '0; v.rst = 1'b1;
    tbl.push_back(v);
    tbl.push_back(E(idle(1), 2'b00, 0, 1, 0, 0, 0, 0, 0));

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n], n);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
